// File: rtl/seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// seg_display_scheduler
//
// Decides what the 4-digit 7-segment display shows. The live speed readout is
// the default. A keyboard command message (FAST/ChUP/SLId) takes over the
// display for a timed hold. A change of speed code blinks the readout for a
// fixed number of on/off phases. All timing counts tick_1k enable pulses.
//
// Ports
//   clk_in      in   1   system clock
//   rst_n       in   1   asynchronous active-low reset
//   tick_1k     in   1   single-cycle 1 kHz timing enable
//   cmd_valid   in   1   command message offered
//   cmd_digits  in   28  {DK1,DK2,DK3,DK4}, gfedcba each; latched on accept
//   cmd_ready   out  1   a command can be accepted this cycle
//   spd_change  in   1   single-cycle pulse: speed code changed
//   spd_digits  in   28  live speed readout {DK1..DK4}
//   dig_out     out  28  registered digits to the seg7 scanner
//   src         out  2   registered source: 0=SPEED, 1=MSG, 2=FLASH
// -----------------------------------------------------------------------------
module seg_display_scheduler #(
    parameter int HOLD_TICKS   = 2000,
    parameter int MIN_TICKS    = 500,
    parameter int BLINK_TICKS  = 250,
    parameter int BLINK_PHASES = 6,
    parameter int TW           = 12
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        tick_1k,
    input  logic        cmd_valid,
    input  logic [27:0] cmd_digits,
    output logic        cmd_ready,
    input  logic        spd_change,
    input  logic [27:0] spd_digits,
    output logic [27:0] dig_out,
    output logic [1:0]  src
);

    localparam int PW = (BLINK_PHASES > 1) ? $clog2(BLINK_PHASES) : 1;

    typedef enum logic [1:0] {
        SPEED = 2'd0,
        MSG   = 2'd1,
        FLASH = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   timer, timer_nx;
    logic [PW-1:0]   phase, phase_nx;
    logic            pend, pend_nx;
    logic [27:0]     msg_reg, msg_nx;
    logic [27:0]     dig_nx;
    logic [1:0]      src_nx;
    logic            accept;

    // Timer holds at all-ones instead of wrapping.
    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // New commands are refused only during the first MIN_TICKS of a hold.
    assign cmd_ready = (state != MSG) || (timer >= TW'(MIN_TICKS));
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        state_nx = state;
        timer_nx = tick_1k ? sat_inc(timer) : timer;
        phase_nx = phase;
        pend_nx  = pend;
        msg_nx   = msg_reg;

        case (state)
            SPEED: begin
                if (accept) begin
                    state_nx = MSG;
                    timer_nx = '0;
                    msg_nx   = cmd_digits;
                    if (spd_change) pend_nx = 1'b1;
                end else if (spd_change) begin
                    state_nx = FLASH;
                    timer_nx = '0;
                    phase_nx = '0;
                    pend_nx  = 1'b0;
                end
            end
            MSG: begin
                if (spd_change) pend_nx = 1'b1;
                // Accept beats hold expiry when both land in the same cycle.
                if (accept) begin
                    timer_nx = '0;
                    msg_nx   = cmd_digits;
                end else if (tick_1k && timer == TW'(HOLD_TICKS - 1)) begin
                    timer_nx = '0;
                    if (pend_nx) begin
                        state_nx = FLASH;
                        phase_nx = '0;
                        pend_nx  = 1'b0;
                    end else begin
                        state_nx = SPEED;
                    end
                end
            end
            FLASH: begin
                if (accept) begin
                    // The interrupted flash reruns once the message hold ends.
                    state_nx = MSG;
                    timer_nx = '0;
                    msg_nx   = cmd_digits;
                    pend_nx  = 1'b1;
                end else if (spd_change) begin
                    timer_nx = '0;
                    phase_nx = '0;
                end else if (tick_1k && timer == TW'(BLINK_TICKS - 1)) begin
                    timer_nx = '0;
                    if (phase == PW'(BLINK_PHASES - 1)) begin
                        state_nx = SPEED;
                        phase_nx = '0;
                    end else begin
                        phase_nx = phase + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = SPEED;
                timer_nx = '0;
                phase_nx = '0;
                pend_nx  = 1'b0;
            end
        endcase
    end

    // Output selection from the current state; registered below.
    always_comb begin
        dig_nx = spd_digits;
        src_nx = state;
        if (state == MSG)
            dig_nx = msg_reg;
        else if (state == FLASH && phase[0])
            dig_nx = 28'h0;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SPEED;
            timer   <= '0;
            phase   <= '0;
            pend    <= 1'b0;
            msg_reg <= '0;
            dig_out <= '0;
            src     <= 2'd0;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            phase   <= phase_nx;
            pend    <= pend_nx;
            msg_reg <= msg_nx;
            dig_out <= dig_nx;
            src     <= src_nx;
        end
    end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scheduler
//
// Directed bench for seg_display_scheduler with short timing parameters
// (HOLD_TICKS=8, MIN_TICKS=3, BLINK_TICKS=2, BLINK_PHASES=4). Inputs change
// 1 ns after a rising edge and outputs are sampled there as well. Each tick_1k
// pulse is followed by two idle cycles so that the registered outputs have
// settled before they are sampled.
// -----------------------------------------------------------------------------
module tb_seg_display_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        tick_1k;
    logic        cmd_valid;
    logic [27:0] cmd_digits;
    logic        cmd_ready;
    logic        spd_change;
    logic [27:0] spd_digits;
    logic [27:0] dig_out;
    logic [1:0]  src;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [27:0] SPD_A = 28'h5A5A5A5;
    localparam logic [27:0] SPD_B = 28'h0C0FFEE;

    seg_display_scheduler #(
        .HOLD_TICKS  (8),
        .MIN_TICKS   (3),
        .BLINK_TICKS (2),
        .BLINK_PHASES(4),
        .TW          (4)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .tick_1k   (tick_1k),
        .cmd_valid (cmd_valid),
        .cmd_digits(cmd_digits),
        .cmd_ready (cmd_ready),
        .spd_change(spd_change),
        .spd_digits(spd_digits),
        .dig_out   (dig_out),
        .src       (src)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic do_tick();
        tick_1k = 1'b1;
        cyc(1);
        tick_1k = 1'b0;
        cyc(2);
    endtask

    // Offer a command for exactly one edge.
    task automatic send_cmd(input logic [27:0] d);
        cmd_digits = d;
        cmd_valid  = 1'b1;
        cyc(1);
        cmd_valid  = 1'b0;
    endtask

    task automatic pulse_spd();
        spd_change = 1'b1;
        cyc(1);
        spd_change = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        tick_1k    = 1'b0;
        cmd_valid  = 1'b1;
        cmd_digits = 28'h1234567;
        spd_change = 1'b0;
        spd_digits = SPD_A;

        // Reset held with a command already offered.
        cyc(3);
        chk("rst_dig", dig_out, 28'h0);
        chk("rst_src", {26'd0, src}, 28'd0);
        chk("rst_ready", {27'd0, cmd_ready}, 28'd1);

        // First edge after release accepts; src follows one cycle later.
        rst_n = 1'b1;
        cyc(1);
        cmd_valid = 1'b0;
        chk("acc0_src_early", {26'd0, src}, 28'd0);
        chk("acc0_ready_busy", {27'd0, cmd_ready}, 28'd0);
        cyc(1);
        chk("acc0_src", {26'd0, src}, 28'd1);
        chk("acc0_dig", dig_out, 28'h1234567);
        repeat (8) do_tick();
        chk("acc0_end_src", {26'd0, src}, 28'd0);

        // Message held for exactly 8 ticks, then back to the speed readout.
        send_cmd(28'hABCDEF1);
        cyc(1);
        for (int i = 1; i <= 8; i++) begin
            do_tick();
            if (i == 7) begin
                chk("hold_t7_src", {26'd0, src}, 28'd1);
                chk("hold_t7_dig", dig_out, 28'hABCDEF1);
            end
        end
        chk("hold_end_src", {26'd0, src}, 28'd0);
        chk("hold_end_dig", dig_out, SPD_A);

        // Live speed updates reach dig_out one cycle later in SPEED.
        spd_digits = SPD_B;
        cyc(1);
        chk("spd_follow", dig_out, SPD_B);

        // A command at hold tick 1 is refused; at tick 4 it is taken.
        send_cmd(28'hAAAAAAA);
        do_tick();
        chk("early_ready", {27'd0, cmd_ready}, 28'd0);
        send_cmd(28'h1111111);
        cyc(1);
        chk("early_msg_kept", dig_out, 28'hAAAAAAA);
        repeat (3) do_tick();
        chk("late_ready", {27'd0, cmd_ready}, 28'd1);
        send_cmd(28'h1111111);
        cyc(1);
        chk("late_msg_new", dig_out, 28'h1111111);
        repeat (7) do_tick();
        chk("rehold_t7_src", {26'd0, src}, 28'd1);
        do_tick();
        chk("rehold_end_src", {26'd0, src}, 28'd0);

        // Speed change in SPEED: phases of 2 ticks each, spd/0/spd/0.
        pulse_spd();
        cyc(1);
        chk("flash_start_src", {26'd0, src}, 28'd2);
        chk("flash_start_dig", dig_out, SPD_B);
        do_tick();  chk("flash_t1", dig_out, SPD_B);
        do_tick();  chk("flash_t2", dig_out, 28'h0);
        do_tick();  chk("flash_t3", dig_out, 28'h0);
        do_tick();  chk("flash_t4", dig_out, SPD_B);
        do_tick();  chk("flash_t5", dig_out, SPD_B);
        do_tick();  chk("flash_t6", dig_out, 28'h0);
        do_tick();  chk("flash_t7", dig_out, 28'h0);
        chk("flash_t7_src", {26'd0, src}, 28'd2);
        do_tick();
        chk("flash_end_src", {26'd0, src}, 28'd0);
        chk("flash_end_dig", dig_out, SPD_B);

        // Speed change at hold tick 2: hold completes, then the flash runs.
        send_cmd(28'h2222222);
        repeat (2) do_tick();
        pulse_spd();
        cyc(1);
        chk("pend_src_msg", {26'd0, src}, 28'd1);
        repeat (5) do_tick();
        chk("pend_t7_src", {26'd0, src}, 28'd1);
        do_tick();
        chk("pend_flash_src", {26'd0, src}, 28'd2);
        repeat (7) do_tick();
        chk("pend_flash_t7", {26'd0, src}, 28'd2);
        do_tick();
        chk("pend_flash_end", {26'd0, src}, 28'd0);

        // Hold expiry and accept on the same edge: the accept wins.
        send_cmd(28'h3333333);
        repeat (7) do_tick();
        cmd_digits = 28'h4444444;
        cmd_valid  = 1'b1;
        tick_1k    = 1'b1;
        cyc(1);
        cmd_valid  = 1'b0;
        tick_1k    = 1'b0;
        cyc(1);
        chk("exp_acc_src", {26'd0, src}, 28'd1);
        chk("exp_acc_dig", dig_out, 28'h4444444);
        repeat (7) do_tick();
        chk("exp_acc_t7", {26'd0, src}, 28'd1);
        do_tick();
        chk("exp_acc_end", {26'd0, src}, 28'd0);

        // Accept during FLASH: message first, flash reruns afterwards.
        pulse_spd();
        do_tick();
        send_cmd(28'h5555555);
        cyc(1);
        chk("flacc_src", {26'd0, src}, 28'd1);
        repeat (8) do_tick();
        chk("flacc_rerun", {26'd0, src}, 28'd2);
        repeat (8) do_tick();
        chk("flacc_end", {26'd0, src}, 28'd0);

        // Accept and speed change together, then reset mid-flash.
        cmd_digits = 28'h6666666;
        cmd_valid  = 1'b1;
        spd_change = 1'b1;
        cyc(1);
        cmd_valid  = 1'b0;
        spd_change = 1'b0;
        cyc(1);
        chk("both_src", {26'd0, src}, 28'd1);
        chk("both_dig", dig_out, 28'h6666666);
        repeat (8) do_tick();
        chk("both_flash", {26'd0, src}, 28'd2);
        repeat (3) do_tick();
        chk("mid_flash_dig", dig_out, 28'h0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_src", {26'd0, src}, 28'd0);
        chk("rst_mid_dig", dig_out, 28'h0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        chk("post_rst_dig", dig_out, SPD_B);
        repeat (8) do_tick();
        chk("post_rst_noflash", {26'd0, src}, 28'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
